// File: rtl/bcd_timer_param.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_param
//  Description : N-digit BCD up/down timer with prescaler, load, clear,
//                lap-hold snapshot and active-low 7-segment outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer_param #(
    parameter int DIGITS        = 4,
    parameter int TICK_DIV      = 50000000,
    parameter int LEADING_BLANK = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  down,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   segs,
    output logic                  tick,
    output logic                  wrap
);

    localparam int             c_pw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);
    localparam logic [c_pw-1:0] c_one  = c_pw'(1);

    // Active-low {g..a} pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h18;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [c_pw-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;

    logic                  w_step;
    logic [4*DIGITS-1:0]   w_stepped;
    logic [4*DIGITS-1:0]   w_loaded;
    logic                  w_carry;
    logic [3:0]            w_nib;
    logic                  w_zero_above;
    logic                  w_blank;

    assign w_step = enable && (presc_q == c_last);

    // Next digit values for one step; every carry/borrow looks at pre-step digits.
    always_comb begin
        w_carry   = 1'b1;
        w_stepped = digits_q;
        w_nib     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib = digits_q[4*i +: 4];
            if (w_carry) begin
                if (down) begin
                    w_stepped[4*i +: 4] = (w_nib == 4'd0) ? 4'd9 : w_nib - 4'd1;
                end else begin
                    w_stepped[4*i +: 4] = (w_nib == 4'd9) ? 4'd0 : w_nib + 4'd1;
                end
            end
            // A carry surviving past the top digit means the whole counter wrapped.
            w_carry = w_carry && (down ? (w_nib == 4'd0) : (w_nib == 4'd9));
        end
    end

    // Load value with out-of-range nibbles saturated to 9.
    always_comb begin
        w_loaded = load_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                w_loaded[4*i +: 4] = 4'd9;
            end
        end
    end

    // Next-state selection: clear > load > step; snapshot follows live while hold is low.
    always_comb begin
        presc_d  = presc_q;
        digits_d = digits_q;
        snap_d   = snap_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        if (!hold) begin
            snap_d = digits_q;
        end
        if (clear) begin
            presc_d  = '0;
            digits_d = '0;
        end else if (load) begin
            presc_d  = '0;
            digits_d = w_loaded;
        end else if (enable) begin
            presc_d = w_step ? '0 : presc_q + c_one;
            if (w_step) begin
                digits_d = w_stepped;
                tick_d   = 1'b1;
                wrap_d   = w_carry;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q  <= '0;
            digits_q <= '0;
            snap_q   <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
            snap_q   <= snap_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bcd_out = hold ? snap_q : digits_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

    // Segment decode with optional leading-zero blanking scanned from the top digit.
    always_comb begin
        segs         = '1;
        w_zero_above = 1'b1;
        w_blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (bcd_out[4*i +: 4] == 4'd0);
            w_blank      = (LEADING_BLANK != 0) && (i > 0) && w_zero_above;
            segs[7*i +: 7] = w_blank ? 7'h7F : seg7(bcd_out[4*i +: 4]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_timer_param
//  Description : Self-checking bench for bcd_timer_param (4 digits, divide 4),
//                one instance without and one with leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_timer_param;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int MAXV     = 9999;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0, enable = 1'b0, clear = 1'b0, load = 1'b0;
    logic        down = 1'b0, hold = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic [15:0] bcd0, bcd1;
    logic [27:0] segs0, segs1;
    logic        tick0, tick1, wrap0, wrap1;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_timer_param #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LEADING_BLANK(0)) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .down(down), .hold(hold),
        .bcd_out(bcd0), .segs(segs0), .tick(tick0), .wrap(wrap0));

    bcd_timer_param #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LEADING_BLANK(1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .down(down), .hold(hold),
        .bcd_out(bcd1), .segs(segs1), .tick(tick1), .wrap(wrap1));

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Integer <-> BCD conversions used by the model.
    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int p;
        r = 16'h0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int sat_val(logic [15:0] b);
        int r;
        int p;
        int d;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_segs(int v, bit lb);
        logic [6:0] pat [10];
        logic [27:0] r;
        int p;
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
        pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h18;
        r = 28'h0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            // Digit i (i>0) is a leading zero exactly when the value is below 10^i.
            if (lb && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
            else                      r[7*i +: 7] = pat[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Behavioural model: live value as an integer, prescaler as a cycle count.
    int m_val = 0, m_snap = 0, m_pre = 0;
    bit m_tick = 0, m_wrap = 0, started = 0;

    always @(posedge CLOCK_50) begin
        bit st;
        int disp;
        if (reset) begin
            m_val = 0; m_snap = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
            started = 1;
        end else begin
            st = enable && (m_pre == TICK_DIV - 1);
            if (!hold) m_snap = m_val;
            m_tick = 0;
            m_wrap = 0;
            if (clear) begin
                m_val = 0; m_pre = 0;
            end else if (load) begin
                m_val = sat_val(load_value); m_pre = 0;
            end else if (enable) begin
                m_pre = st ? 0 : m_pre + 1;
                if (st) begin
                    m_tick = 1;
                    if (!down) begin
                        m_wrap = (m_val == MAXV);
                        m_val  = (m_val + 1) % (MAXV + 1);
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val == 0) ? MAXV : m_val - 1;
                    end
                end
            end
        end
        #1;
        if (started) begin
            disp = hold ? m_snap : m_val;
            chk("bcd_out",  {48'h0, bcd0},  {48'h0, to_bcd(disp)});
            chk("bcd_out_lb", {48'h0, bcd1}, {48'h0, to_bcd(disp)});
            chk("segs",     {36'h0, segs0}, {36'h0, exp_segs(disp, 0)});
            chk("segs_lb",  {36'h0, segs1}, {36'h0, exp_segs(disp, 1)});
            chk("tick",     {63'h0, tick0}, {63'h0, m_tick});
            chk("wrap",     {63'h0, wrap0}, {63'h0, m_wrap});
        end
    end

    task automatic do_load(logic [15:0] v);
        load = 1'b1; load_value = v;
        @(negedge CLOCK_50);
        load = 1'b0;
    endtask

    initial begin
        int tcnt;
        int wcnt;
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("reset_bcd",  {48'h0, bcd0},  64'h0);
        chk("reset_segs", {36'h0, segs0}, {36'h0, 7'h40, 7'h40, 7'h40, 7'h40});
        chk("reset_segs_lb", {36'h0, segs1}, {36'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("reset_tick", {63'h0, tick0}, 64'h0);

        // Free run up for 40 enabled cycles.
        reset = 1'b0; enable = 1'b1; down = 1'b0;
        tcnt = 0; wcnt = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (tick0) tcnt++;
            if (wrap0) wcnt++;
        end
        chk("run40_bcd",  {48'h0, bcd0}, 64'h0010);
        chk("run40_ticks", 64'(tcnt), 64'd10);
        chk("run40_wraps", 64'(wcnt), 64'd0);

        // Carry ripple and wrap upward.
        enable = 1'b0;
        do_load(16'h0999);
        enable = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("up_ripple", {48'h0, bcd0}, 64'h1000);
        chk("up_ripple_wrap", {63'h0, wrap0}, 64'h0);
        enable = 1'b0;
        do_load(16'h9999);
        enable = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("up_wrap_bcd", {48'h0, bcd0}, 64'h0000);
        chk("up_wrap_tick", {63'h0, tick0}, 64'h1);
        chk("up_wrap_wrap", {63'h0, wrap0}, 64'h1);
        @(negedge CLOCK_50);
        chk("wrap_one_cycle", {62'h0, tick0, wrap0}, 64'h0);

        // Borrow ripple and wrap downward.
        enable = 1'b0; down = 1'b1;
        do_load(16'h1000);
        enable = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("down_borrow", {48'h0, bcd0}, 64'h0999);
        enable = 1'b0;
        do_load(16'h0000);
        enable = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        chk("down_wrap_bcd", {48'h0, bcd0}, 64'h9999);
        chk("down_wrap_wrap", {63'h0, wrap0}, 64'h1);

        // Lap hold.
        enable = 1'b0; down = 1'b0;
        do_load(16'h0012);
        @(negedge CLOCK_50);
        hold = 1'b1; enable = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        chk("hold_frozen", {48'h0, bcd0}, 64'h0012);
        hold = 1'b0;
        #1;
        chk("hold_release", {48'h0, bcd0}, 64'h0015);

        // Load saturation, load+clear priority, reset mid-prescale.
        @(negedge CLOCK_50);
        enable = 1'b0;
        do_load(16'h00AF);
        chk("load_sat", {48'h0, bcd0}, 64'h0099);
        clear = 1'b1; load = 1'b1; load_value = 16'h4321;
        @(negedge CLOCK_50);
        clear = 1'b0; load = 1'b0;
        chk("clear_wins", {48'h0, bcd0}, 64'h0000);
        enable = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("post_reset_no_tick", {63'h0, tick0}, 64'h0);
        end
        @(negedge CLOCK_50);
        chk("post_reset_tick", {63'h0, tick0}, 64'h1);

        // Leading-zero blanking.
        enable = 1'b0;
        do_load(16'h0105);
        chk("blank_0105", {36'h0, segs1}, {36'h0, 7'h7F, 7'h79, 7'h40, 7'h12});
        chk("noblank_0105", {36'h0, segs0}, {36'h0, 7'h40, 7'h79, 7'h40, 7'h12});
        do_load(16'h0000);
        chk("blank_zero", {36'h0, segs1}, {36'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Randomised traffic against the model.
        repeat (3000) begin
            reset      = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 99) == 0);
            load       = ($urandom_range(0, 29) == 0);
            enable     = ($urandom_range(0, 9) < 8);
            down       = ($urandom_range(0, 299) < 1) ? ~down : down;
            hold       = ($urandom_range(0, 49) == 0) ? ~hold : hold;
            load_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_value = 16'h9998;
            @(negedge CLOCK_50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
